puf_batch_scheduler: RTL and testbench

// - Host-facing scheduler for the TERO evaluation FSM: accepts challenges over valid/ready, drives start/challenge one at a time.
// - Captures each per-loop count on the one-cycle store strobe, scales it to an average, tags it, pushes to a response FIFO.
// - Strobe cannot be stalled, so a challenge is only launched when the FIFO has room for NUM_LOOPS entries.

---
 rtl/puf_batch_scheduler_pkg.sv | 35 +++
 rtl/puf_batch_scheduler_rsp_fifo.sv | 67 ++++++
 rtl/puf_batch_scheduler.sv | 129 ++++++++++++
 tb/tb_puf_batch_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_batch_scheduler_pkg.sv
// Shared types and constants for the PUF batch scheduler slice.
// Holds the scheduler state enum, the response FIFO entry layout and the
// derived widths used by both the top and the response FIFO.
package puf_batch_scheduler_pkg;

    localparam int unsigned NUM_LOOPS      = 4;
    localparam int unsigned CHALLENGE_BITS = 4;
    localparam int unsigned CNT_BITS       = 29;
    localparam int unsigned AVG_SHIFT      = 12;
    localparam int unsigned SEQ_BITS       = 4;
    localparam int unsigned FIFO_DEPTH     = 8;

    localparam int unsigned LOOP_BITS      = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
    localparam int unsigned AVG_BITS       = CNT_BITS - AVG_SHIFT;
    localparam int unsigned FIFO_CNT_BITS  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic [SEQ_BITS-1:0]  seq;
        logic [LOOP_BITS-1:0] loop;
        logic [AVG_BITS-1:0]  avg;
    } rsp_entry_t;

    // Summed count to average: truncating shift, no rounding.
    function automatic logic [AVG_BITS-1:0] count_to_avg(input logic [CNT_BITS-1:0] cnt);
        return AVG_BITS'(cnt >> AVG_SHIFT);
    endfunction

endpackage

// File: rtl/puf_batch_scheduler_rsp_fifo.sv
// Synchronous response FIFO of rsp_entry_t.
// Ports: clk, reset (async, active-high), push/wr_data write side,
// pop/rd_data/valid read side (rd_data valid when valid=1), full flag,
// count_next = occupancy after the current cycle's push/pop.
// A push while full is accepted only when a pop happens in the same cycle.
module puf_rsp_fifo
    import puf_batch_scheduler_pkg::*;
#(
    parameter  int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  rsp_entry_t       wr_data,
    input  logic             pop,
    output rsp_entry_t       rd_data,
    output logic             valid,
    output logic             full,
    output logic [CNT_W-1:0] count_next
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rsp_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualified push/pop and next occupancy.
    always_comb begin
        do_pop     = pop & valid;
        do_push    = push & (~full | do_pop);
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
            valid <= (count_next != '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/puf_batch_scheduler.sv
// Host-facing scheduler for the TERO evaluation FSM.
// Ports: cmd_valid/cmd_ready/cmd_challenge host command side;
// evl_start/evl_challenge/evl_done/evl_store/evl_select/puf_count to/from
// the evaluation FSM and shared counter; rsp_valid/rsp_ready/rsp_avg/
// rsp_loop/rsp_seq response FIFO head; busy, sticky err_overflow/err_spurious.
// A challenge is launched only when the FIFO can absorb NUM_LOOPS strobes,
// because the store strobe cannot be back-pressured.
module puf_batch_scheduler
    import puf_batch_scheduler_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CHALLENGE_BITS-1:0] cmd_challenge,
    output logic                      evl_start,
    output logic [CHALLENGE_BITS-1:0] evl_challenge,
    input  logic                      evl_done,
    input  logic                      evl_store,
    input  logic [LOOP_BITS-1:0]      evl_select,
    input  logic [CNT_BITS-1:0]       puf_count,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AVG_BITS-1:0]       rsp_avg,
    output logic [LOOP_BITS-1:0]      rsp_loop,
    output logic [SEQ_BITS-1:0]       rsp_seq,
    output logic                      busy,
    output logic                      err_overflow,
    output logic                      err_spurious
);

    if (FIFO_DEPTH < NUM_LOOPS) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least NUM_LOOPS");
    end

    sched_state_t             state;
    sched_state_t             state_d;
    logic                     cmd_hs;
    logic                     rsp_pop;
    logic                     store_run;
    logic                     fifo_push;
    logic                     fifo_full;
    logic [FIFO_CNT_BITS-1:0] fifo_count_next;
    rsp_entry_t               wr_entry;
    rsp_entry_t               rd_entry;
    logic [SEQ_BITS-1:0]      seq_q;
    logic                     evl_start_d;
    logic                     busy_d;
    logic                     cmd_ready_d;

    // Handshakes and strobe capture qualification.
    always_comb begin
        cmd_hs    = cmd_valid & cmd_ready;
        rsp_pop   = rsp_valid & rsp_ready;
        store_run = evl_store & (state == ST_RUN);
        fifo_push = store_run & (~fifo_full | rsp_pop);
        wr_entry  = '{seq: seq_q, loop: evl_select, avg: count_to_avg(puf_count)};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:    if (cmd_hs)    state_d = ST_START;
            ST_START:                  state_d = ST_RUN;
            ST_RUN:     if (evl_done)  state_d = ST_RELEASE;
            ST_RELEASE: if (!evl_done) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the flops below present a clean Moore view.
    always_comb begin
        evl_start_d = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b0;
        evl_start_d = (state_d == ST_START) || (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        // Credit only from settled occupancy: no speculative pops.
        cmd_ready_d = (state_d == ST_IDLE) &&
                      (fifo_count_next <= FIFO_CNT_BITS'(FIFO_DEPTH - NUM_LOOPS));
    end

    // Registered outputs, sequence tag and sticky errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evl_start     <= 1'b0;
            busy          <= 1'b0;
            cmd_ready     <= 1'b0;
            evl_challenge <= '0;
            seq_q         <= '0;
            err_overflow  <= 1'b0;
            err_spurious  <= 1'b0;
        end else begin
            evl_start <= evl_start_d;
            busy      <= busy_d;
            cmd_ready <= cmd_ready_d;
            if (cmd_hs)                         evl_challenge <= cmd_challenge;
            if ((state == ST_RUN) && evl_done)  seq_q         <= seq_q + SEQ_BITS'(1);
            if (store_run && !fifo_push)        err_overflow  <= 1'b1;
            if (evl_store && (state != ST_RUN)) err_spurious  <= 1'b1;
        end
    end

    puf_rsp_fifo #(
        .DEPTH      (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .wr_data    (wr_entry),
        .pop        (rsp_pop),
        .rd_data    (rd_entry),
        .valid      (rsp_valid),
        .full       (fifo_full),
        .count_next (fifo_count_next)
    );

    assign rsp_avg  = rd_entry.avg;
    assign rsp_loop = rd_entry.loop;
    assign rsp_seq  = rd_entry.seq;

endmodule

// File: tb/tb_puf_batch_scheduler.sv
// Bench for puf_batch_scheduler: a behavioural TERO evaluation FSM drives the
// eval side, a queue-based reference model predicts every output each cycle.
module tb_puf_batch_scheduler;
    import puf_batch_scheduler_pkg::*;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [CHALLENGE_BITS-1:0] cmd_challenge;
    logic                      evl_start;
    logic [CHALLENGE_BITS-1:0] evl_challenge;
    logic                      evl_done;
    logic                      evl_store;
    logic [LOOP_BITS-1:0]      evl_select;
    logic [CNT_BITS-1:0]       puf_count;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [AVG_BITS-1:0]       rsp_avg;
    logic [LOOP_BITS-1:0]      rsp_loop;
    logic [SEQ_BITS-1:0]       rsp_seq;
    logic                      busy;
    logic                      err_overflow;
    logic                      err_spurious;

    logic host_ready = 1'b0;
    logic pop_pulse;
    logic ev_rdy;
    logic ev_store;
    logic spur_store;
    assign rsp_ready = host_ready | pop_pulse | ev_rdy;
    assign evl_store = ev_store | spur_store;

    puf_batch_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_challenge (cmd_challenge),
        .evl_start     (evl_start),
        .evl_challenge (evl_challenge),
        .evl_done      (evl_done),
        .evl_store     (evl_store),
        .evl_select    (evl_select),
        .puf_count     (puf_count),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_avg       (rsp_avg),
        .rsp_loop      (rsp_loop),
        .rsp_seq       (rsp_seq),
        .busy          (busy),
        .err_overflow  (err_overflow),
        .err_spurious  (err_spurious)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural TERO evaluation FSM (stimulus) ----------------
    int ev_st, ev_cnt, ev_idx, ev_n;
    bit ev_fixed = 0, ev_extra = 0, ev_pop_last = 0, ev_rand_n = 0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            ev_st      <= 0;
            ev_cnt     <= 0;
            ev_idx     <= 0;
            ev_n       <= 0;
            ev_store   <= 1'b0;
            ev_rdy     <= 1'b0;
            evl_done   <= 1'b0;
            evl_select <= '0;
            puf_count  <= '0;
        end else begin
            ev_store <= 1'b0;
            ev_rdy   <= 1'b0;
            case (ev_st)
                0: if (evl_start) begin
                    ev_cnt <= int'($urandom_range(0, 2));
                    ev_idx <= 0;
                    ev_n   <= ev_extra  ? int'(NUM_LOOPS) + 1 :
                              ev_rand_n ? int'($urandom_range(1, NUM_LOOPS)) : int'(NUM_LOOPS);
                    ev_st  <= 1;
                end
                1: if (ev_cnt != 0) begin
                    ev_cnt <= ev_cnt - 1;
                end else begin
                    ev_store   <= 1'b1;
                    evl_select <= LOOP_BITS'(ev_idx);
                    puf_count  <= ev_fixed ? CNT_BITS'((ev_idx + 5) << AVG_SHIFT) : CNT_BITS'($urandom);
                    if (ev_pop_last && ev_idx == ev_n - 1) ev_rdy <= 1'b1;
                    ev_idx <= ev_idx + 1;
                    if (ev_idx == ev_n - 1) ev_st <= 2;
                    else ev_cnt <= int'($urandom_range(0, 2));
                end
                2: begin
                    evl_done <= 1'b1;
                    ev_st    <= 3;
                end
                3: if (!evl_start) begin
                    ev_cnt <= int'($urandom_range(0, 2));
                    ev_st  <= 4;
                end
                default: if (ev_cnt == 0) begin
                    evl_done <= 1'b0;
                    ev_st    <= 0;
                end else begin
                    ev_cnt <= ev_cnt - 1;
                end
            endcase
        end
    end

    // Random host back-pressure: 0 = never, 1 = always, 2 = coin flip.
    int rdy_mode = 0;
    always @(negedge clk) host_ready <= (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);

    // ---------------- reference model ----------------
    typedef struct {
        int seq;
        int loop;
        int avg;
    } exp_t;

    exp_t                      m_q[$];
    bit                        m_busy, m_done_seen, m_just_started, m_ready, m_ovf, m_spur;
    int                        m_seq;
    logic [CHALLENGE_BITS-1:0] m_chal;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_busy = 0; m_done_seen = 0; m_just_started = 0;
                m_ready = 0; m_ovf = 0; m_spur = 0; m_seq = 0; m_chal = '0;
            end else begin
                bit   pop_now, in_run;
                exp_t e;
                pop_now = (m_q.size() != 0) && rsp_ready;
                in_run  = m_busy && !m_done_seen && !m_just_started;
                if (pop_now) void'(m_q.pop_front());
                if (evl_store) begin
                    if (!in_run) m_spur = 1;
                    else if (m_q.size() < FIFO_DEPTH) begin
                        e.seq  = m_seq;
                        e.loop = int'(evl_select);
                        e.avg  = int'(puf_count) / (1 << AVG_SHIFT);
                        m_q.push_back(e);
                    end else m_ovf = 1;
                end
                if (m_busy) begin
                    if (m_just_started) m_just_started = 0;
                    else if (!m_done_seen) begin
                        if (evl_done) begin
                            m_done_seen = 1;
                            m_seq = (m_seq + 1) % (1 << SEQ_BITS);
                        end
                    end else if (!evl_done) m_busy = 0;
                end else if (cmd_valid && m_ready) begin
                    m_busy = 1; m_just_started = 1; m_done_seen = 0; m_chal = cmd_challenge;
                end
                m_ready = !m_busy && ((FIFO_DEPTH - m_q.size()) >= NUM_LOOPS);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
                chk("evl_start", 64'(evl_start), 64'(m_busy && !m_done_seen));
                chk("busy", 64'(busy), 64'(m_busy));
                chk("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
                chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
                chk("err_spurious", 64'(err_spurious), 64'(m_spur));
                if (m_busy && !m_done_seen) chk("evl_challenge", 64'(evl_challenge), 64'(m_chal));
                if (m_q.size() != 0) begin
                    chk("rsp_avg", 64'(rsp_avg), 64'(m_q[0].avg));
                    chk("rsp_loop", 64'(rsp_loop), 64'(m_q[0].loop));
                    chk("rsp_seq", 64'(rsp_seq), 64'(m_q[0].seq));
                end
            end
        end
    end

    // ---------------- host tasks ----------------
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rst_evl_start", 64'(evl_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_err_overflow", 64'(err_overflow), 64'd0);
        chk("rst_err_spurious", 64'(err_spurious), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [CHALLENGE_BITS-1:0] c);
        int n = 0;
        @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_challenge = c;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("cmd_accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || ev_st != 0) && n < 3000);
        if (n >= 3000) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic pop_n(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk) pop_pulse = 1'b1;
            @(negedge clk) pop_pulse = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0; cmd_challenge = '0; spur_store = 1'b0; pop_pulse = 1'b0;
        do_reset();

        // Fixed counts 0x5000..0x8000 give averages 5..8 on loops 0..3, seq 0.
        rdy_mode = 0;
        ev_fixed = 1;
        send_cmd(4'h5);
        chk("t1_evl_start", 64'(evl_start), 64'd1);
        chk("t1_evl_challenge", 64'(evl_challenge), 64'h5);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            chk("t1_rsp_avg", 64'(rsp_avg), 64'(5 + i));
            chk("t1_rsp_loop", 64'(rsp_loop), 64'(i));
            chk("t1_rsp_seq", 64'(rsp_seq), 64'd0);
            pop_n(1);
        end
        chk("t1_drained", 64'(rsp_valid), 64'd0);
        ev_fixed = 0;

        // Back-to-back commands with the host always ready.
        rdy_mode = 1;
        send_cmd(4'h3);
        send_cmd(4'hA);
        wait_idle();
        repeat (4) @(negedge clk);

        // Two commands fill the FIFO; credit returns only after four pops.
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        send_cmd(4'h1);
        wait_idle();
        send_cmd(4'h2);
        wait_idle();
        chk("t3_ready_full", 64'(cmd_ready), 64'd0);
        pop_n(3);
        chk("t3_ready_after3", 64'(cmd_ready), 64'd0);
        pop_n(1);
        chk("t3_ready_after4", 64'(cmd_ready), 64'd1);
        chk("t3_no_overflow", 64'(err_overflow), 64'd0);

        // Strobe while idle, then one strobe too many into a full FIFO.
        @(negedge clk) spur_store = 1'b1;
        @(negedge clk) spur_store = 1'b0;
        @(negedge clk);
        chk("t4_spurious", 64'(err_spurious), 64'd1);
        chk("t4_ovf_clear", 64'(err_overflow), 64'd0);
        ev_extra = 1;
        send_cmd(4'h6);
        wait_idle();
        ev_extra = 0;
        chk("t4_overflow", 64'(err_overflow), 64'd1);

        // Full FIFO with a simultaneous push and pop keeps occupancy.
        do_reset();
        send_cmd(4'h7);
        wait_idle();
        ev_extra = 1;
        ev_pop_last = 1;
        send_cmd(4'h8);
        wait_idle();
        ev_extra = 0;
        ev_pop_last = 0;
        chk("t5_no_overflow", 64'(err_overflow), 64'd0);
        pop_n(3);
        chk("t5_ready_after3", 64'(cmd_ready), 64'd0);
        pop_n(1);
        chk("t5_ready_after4", 64'(cmd_ready), 64'd1);

        // Reset in the middle of an evaluation.
        rdy_mode = 1;
        send_cmd(4'h9);
        chk("t6_running", 64'(evl_start), 64'd1);
        do_reset();

        // Sixteen commands wrap the tag; the seventeenth is tagged 0 again.
        ev_rand_n = 1;
        for (int i = 0; i < 16; i++) begin
            send_cmd(CHALLENGE_BITS'($urandom));
            wait_idle();
        end
        rdy_mode = 0;
        repeat (4) @(negedge clk);
        chk("t7_drained", 64'(rsp_valid), 64'd0);
        ev_rand_n = 0;
        send_cmd(4'hC);
        wait_idle();
        chk("t7_wrap_seq", 64'(rsp_seq), 64'd0);
        chk("t7_wrap_loop", 64'(rsp_loop), 64'd0);

        // Random traffic with random back-pressure.
        rdy_mode = 2;
        ev_rand_n = 1;
        for (int i = 0; i < 30; i++) send_cmd(CHALLENGE_BITS'($urandom));
        wait_idle();
        rdy_mode = 1;
        repeat (20) @(negedge clk);
        chk("t8_drained", 64'(rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
